router_reg: RTL and testbench

ROUTER_REG -- requirements
Module: router_reg

---
 rtl/router_pkg.sv | 13 +
 rtl/router_reg_parity.sv | 58 +++++
 rtl/router_reg.sv | 95 +++++++++
 tb/tb_router_reg.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the router register slice: data width,
// header field layout and the reserved destination address.
package router_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 2;
    localparam int LEN_LSB  = 2;
    localparam int LEN_W    = 6;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_reg_parity.sv
// Running XOR parity over header+payload and compare against the
// received parity byte; err updates once per packet.
module router_reg_parity #(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              packet_valid,
    input  logic              full_state,
    input  logic [DATA_W-1:0] header,
    input  logic [DATA_W-1:0] datain,
    input  logic              parity_done,
    output logic              err
);

    logic [DATA_W-1:0] int_par;
    logic [DATA_W-1:0] pkt_par;
    logic              done_d;

    always_ff @(posedge clk) begin
        if (resetn) begin
            int_par <= '0;
        end else if (detect_add) begin
            int_par <= '0;
        end else if (lfd_state) begin
            int_par <= int_par ^ header;
        end else if (ld_state && packet_valid && !full_state) begin
            int_par <= int_par ^ datain;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            pkt_par <= '0;
        end else if (ld_state && !packet_valid) begin
            pkt_par <= datain;
        end
    end

    // compare only on the first cycle parity_done is seen high
    always_ff @(posedge clk) begin
        if (resetn) begin
            done_d <= 1'b0;
            err    <= 1'b0;
        end else begin
            done_d <= parity_done;
            if (detect_add) begin
                err <= 1'b0;
            end else if (parity_done && !done_d) begin
                err <= (int_par != pkt_par);
            end
        end
    end

endmodule

// File: rtl/router_reg.sv
// Router datapath register: header capture, output byte staging and
// packet-end flags. Parity checking is built with ROUTER_REG_PARITY_CHECK_EN.
module router_reg #(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              packet_valid,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dout,
    output logic              err,
    output logic              parity_done,
    output logic              low_packet_valid
);

    import router_pkg::*;

    logic [DATA_W-1:0] header;
    logic [DATA_W-1:0] fsb;
    logic              hdr_ok;

    assign hdr_ok = datain[ADDR_LSB +: ADDR_W] != ADDR_INVALID;

    always_ff @(posedge clk) begin
        if (resetn) begin
            header <= '0;
        end else if (detect_add && packet_valid && hdr_ok && !full_state) begin
            header <= datain;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            dout <= '0;
            fsb  <= '0;
        end else if (lfd_state) begin
            dout <= header;
        end else if (ld_state && !fifo_full) begin
            dout <= datain;
        end else if (ld_state) begin
            fsb <= datain;
        end else if (laf_state) begin
            dout <= fsb;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if ((ld_state && !fifo_full && !packet_valid) ||
                     (laf_state && low_packet_valid && !parity_done)) begin
            parity_done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            low_packet_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end else if (ld_state && !packet_valid) begin
            low_packet_valid <= 1'b1;
        end
    end

`ifdef ROUTER_REG_PARITY_CHECK_EN
    router_reg_parity #(
        .DATA_W(DATA_W)
    ) u_parity (
        .clk         (clk),
        .resetn      (resetn),
        .detect_add  (detect_add),
        .lfd_state   (lfd_state),
        .ld_state    (ld_state),
        .packet_valid(packet_valid),
        .full_state  (full_state),
        .header      (header),
        .datain      (datain),
        .parity_done (parity_done),
        .err         (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Directed checks for router_reg: reset, good/bad packets, fifo_full
// staging, invalid header, rst_int_reg priority and mid-packet reset.
module tb_router_reg;

`ifdef ROUTER_REG_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       packet_valid;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] datain;
    logic [7:0] dout;
    logic       err;
    logic       parity_done;
    logic       low_packet_valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pay [8] = '{8'h3C, 8'hA1, 8'h07, 8'hF0,
                            8'h55, 8'h9E, 8'h12, 8'hC8};

    always #5 clk = ~clk;

    router_reg #(.DATA_W(8)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .packet_valid    (packet_valid),
        .fifo_full       (fifo_full),
        .detect_add      (detect_add),
        .lfd_state       (lfd_state),
        .ld_state        (ld_state),
        .laf_state       (laf_state),
        .full_state      (full_state),
        .rst_int_reg     (rst_int_reg),
        .datain          (datain),
        .dout            (dout),
        .err             (err),
        .parity_done     (parity_done),
        .low_packet_valid(low_packet_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        packet_valid = 1'b0;
        fifo_full    = 1'b0;
        detect_add   = 1'b0;
        lfd_state    = 1'b0;
        ld_state     = 1'b0;
        laf_state    = 1'b0;
        full_state   = 1'b0;
        rst_int_reg  = 1'b0;
        datain       = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] flip);
        logic [7:0] par;
        clr(); detect_add = 1; packet_valid = 1; datain = 8'h22;
        step();
        chk("pd_clr", {31'd0, parity_done}, 0);
        chk("err_clr", {31'd0, err}, 0);
        clr(); lfd_state = 1; packet_valid = 1;
        step();
        chk("hdr_out", {24'd0, dout}, 32'h22);
        par = 8'h22;
        for (int i = 0; i < 8; i++) begin
            clr(); ld_state = 1; packet_valid = 1; datain = pay[i];
            step();
            chk("payload", {24'd0, dout}, {24'd0, pay[i]});
            par = par ^ pay[i];
        end
        clr(); ld_state = 1; packet_valid = 0; datain = par ^ flip;
        step();
        chk("pd_set", {31'd0, parity_done}, 1);
        chk("lpv_set", {31'd0, low_packet_valid}, 1);
        chk("err_early", {31'd0, err}, 0);
        clr();
        step();
        chk("err_eval", {31'd0, err}, {31'd0, PAR_EN && (flip != 0)});
        chk("pd_hold", {31'd0, parity_done}, 1);
    endtask

    initial begin
        clr();
        resetn = 1'b1;
        step();
        chk("rst_dout", {24'd0, dout}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_pd", {31'd0, parity_done}, 0);
        chk("rst_lpv", {31'd0, low_packet_valid}, 0);
        resetn = 1'b0;

        send_pkt(8'h00);
        send_pkt(8'hFF);

        clr(); detect_add = 1; packet_valid = 1; datain = 8'h22;
        step();
        chk("da_err_clr", {31'd0, err}, 0);
        chk("da_pd_clr", {31'd0, parity_done}, 0);

        clr(); lfd_state = 1; packet_valid = 1;
        step();
        clr(); ld_state = 1; packet_valid = 1; datain = 8'h11;
        step();
        chk("ff_pre", {24'd0, dout}, 32'h11);
        clr(); ld_state = 1; packet_valid = 1; fifo_full = 1;
        datain = 8'h5A;
        step();
        chk("ff_hold", {24'd0, dout}, 32'h11);
        clr(); laf_state = 1;
        step();
        chk("laf_out", {24'd0, dout}, 32'h5A);

        clr(); detect_add = 1; packet_valid = 1; datain = 8'h30;
        step();
        clr(); detect_add = 1; packet_valid = 1; datain = 8'h23;
        step();
        clr(); lfd_state = 1; packet_valid = 1;
        step();
        chk("bad_addr", {24'd0, dout}, 32'h30);

        chk("lpv_pre", {31'd0, low_packet_valid}, 1);
        clr(); ld_state = 1; rst_int_reg = 1;
        step();
        chk("lpv_rst_prio", {31'd0, low_packet_valid}, 0);
        clr(); ld_state = 1;
        step();
        chk("lpv_reset", {31'd0, low_packet_valid}, 1);

        clr(); detect_add = 1; packet_valid = 1; datain = 8'h22;
        step();
        clr(); lfd_state = 1; packet_valid = 1;
        step();
        clr(); ld_state = 1; packet_valid = 1; datain = 8'h44;
        step();
        chk("mid_pre", {24'd0, dout}, 32'h44);
        clr(); resetn = 1; ld_state = 1; packet_valid = 1;
        datain = 8'h99;
        step();
        chk("mid_dout", {24'd0, dout}, 0);
        chk("mid_pd", {31'd0, parity_done}, 0);
        chk("mid_lpv", {31'd0, low_packet_valid}, 0);
        chk("mid_err", {31'd0, err}, 0);
        resetn = 0; clr();
        step();
        chk("post_dout", {24'd0, dout}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
